// File: rtl/reg_d_pkg.sv
//------------------------------------------------------------------------------
// Module  : reg_d_pkg
// Purpose : Library-wide defaults shared by the reg_d storage register.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_d_pkg;

  localparam int          C_REG_D_DEF_WIDTH = 8;
  localparam logic [63:0] C_REG_D_DEF_RST   = 64'h0;

endpackage : reg_d_pkg

`default_nettype wire

// File: rtl/reg_d.sv
//------------------------------------------------------------------------------
// Module  : reg_d
// Purpose : Parameterised D-type register; q follows d one clock later,
//           asynchronously forced to RST_VALUE while Rst is low.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_d
  import reg_d_pkg::*;
#(
  parameter int                   DATAWIDTH = C_REG_D_DEF_WIDTH,
  parameter logic [DATAWIDTH-1:0] RST_VALUE = DATAWIDTH'(C_REG_D_DEF_RST)
) (
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 Clk,
  input  logic                 Rst,
  output logic [DATAWIDTH-1:0] q
);

  logic [DATAWIDTH-1:0] r_q;

  // Reset has priority, so a reset coinciding with a clock edge still yields RST_VALUE.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_q <= RST_VALUE;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : reg_d

`default_nettype wire

// File: tb/tb_reg_d.sv
//------------------------------------------------------------------------------
// Module  : tb_reg_d
// Purpose : Directed self-checking bench for reg_d at widths 8, 1 and 32.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_d;

  logic        Clk;
  logic        Rst;
  logic [7:0]  r_d8;
  logic [0:0]  r_d1;
  logic [31:0] r_d32;
  logic [7:0]  w_q8;
  logic [0:0]  w_q1;
  logic [31:0] w_q32;

  int n_checks;
  int n_errors;

  reg_d #(.DATAWIDTH(8)) u_dut8 (
    .d   (r_d8),
    .Clk (Clk),
    .Rst (Rst),
    .q   (w_q8)
  );

  reg_d #(.DATAWIDTH(1), .RST_VALUE(1'b1)) u_dut1 (
    .d   (r_d1),
    .Clk (Clk),
    .Rst (Rst),
    .q   (w_q1)
  );

  reg_d #(.DATAWIDTH(32), .RST_VALUE(32'hDEADBEEF)) u_dut32 (
    .d   (r_d32),
    .Clk (Clk),
    .Rst (Rst),
    .q   (w_q32)
  );

  initial Clk = 1'b0;
  always #20 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    logic [7:0]  v8;
    logic [0:0]  v1;
    logic [31:0] v32;
    n_checks = 0;
    n_errors = 0;
    Rst   = 1'b1;
    r_d8  = 8'd10;
    r_d1  = 1'b0;
    r_d32 = 32'h1234_5678;

    // 1. asynchronous reset before any clock edge
    #5 Rst = 1'b0;
    #1;
    chk("rst_async_q8",  w_q8,  8'd0);
    chk("rst_async_q1",  w_q1,  1'b1);
    chk("rst_async_q32", w_q32, 32'hDEADBEEF);
    repeat (2) begin
      @(posedge Clk); #1;
      chk("rst_hold_q8",  w_q8,  8'd0);
      chk("rst_hold_q32", w_q32, 32'hDEADBEEF);
    end

    // 2. release mid-cycle; q only changes at the next rising edge
    @(negedge Clk) Rst = 1'b1;
    #1 chk("release_no_load", w_q8, 8'd0);
    @(posedge Clk); #1;
    chk("release_load_q8",  w_q8,  8'd10);
    chk("release_load_q32", w_q32, 32'h1234_5678);
    chk("release_load_q1",  w_q1,  1'b0);

    // 3. mid-cycle d change held off until next edge
    @(negedge Clk) r_d8 = 8'd20;
    #1 chk("midcycle_hold", w_q8, 8'd10);
    @(posedge Clk); #1 chk("midcycle_load", w_q8, 8'd20);
    @(negedge Clk) r_d8 = 8'd55;
    @(posedge Clk); #1 chk("load_55", w_q8, 8'd55);

    // 4. two d changes in one period: only the value at the edge is captured
    @(negedge Clk) r_d8 = 8'd20;
    #5 chk("glitch_hold", w_q8, 8'd55);
    r_d8 = 8'd30;
    @(posedge Clk); #1 chk("glitch_capture", w_q8, 8'd30);
    @(negedge Clk) chk("glitch_stable", w_q8, 8'd30);

    // 5. reset pulse between edges, then release with 0xFF
    @(posedge Clk); #10 Rst = 1'b0;
    #1 chk("pulse_async_q8", w_q8, 8'd0);
    r_d8 = 8'hFF;
    @(negedge Clk) Rst = 1'b1;
    #1 chk("pulse_release_hold", w_q8, 8'd0);
    @(posedge Clk); #1 chk("pulse_reload", w_q8, 8'hFF);

    // reset asserted exactly at a rising edge wins over the capture
    @(negedge Clk) begin
      r_d8  = 8'hA5;
      r_d32 = 32'hCAFE_F00D;
    end
    @(posedge Clk) Rst = 1'b0;
    #1;
    chk("edge_rst_q8",  w_q8,  8'd0);
    chk("edge_rst_q32", w_q32, 32'hDEADBEEF);
    @(negedge Clk) Rst = 1'b1;

    // 6. random data on all widths against a one-cycle-delayed model
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      v8    = 8'($urandom);
      v1    = 1'($urandom);
      v32   = $urandom;
      r_d8  = v8;
      r_d1  = v1;
      r_d32 = v32;
      #1 chk("rand_pre_q8", w_q8, (i == 0) ? 64'(8'hA5) : 64'(w_q8));
      @(posedge Clk); #1;
      chk("rand_q8",  w_q8,  v8);
      chk("rand_q1",  w_q1,  v1);
      chk("rand_q32", w_q32, v32);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reg_d

`default_nettype wire
